// File: rtl/mab_ctrl.sv
// Sequencer and weight store for the 8-tap modified adder block of the LMS filter.
// Captures sample/error/step controls per update, then commits the block's new weights.
module mab_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  x_in,
    input  logic [9:0]  err,
    input  logic [2:0]  mu_sel,
    input  logic        freeze,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [9:0]  wr_data,
    input  logic [9:0]  W1,
    input  logic [9:0]  W2,
    input  logic [9:0]  W3,
    input  logic [9:0]  W4,
    input  logic [9:0]  W5,
    input  logic [9:0]  W6,
    input  logic [9:0]  W7,
    input  logic [9:0]  W8,
    output logic [9:0]  w1,
    output logic [9:0]  w2,
    output logic [9:0]  w3,
    output logic [9:0]  w4,
    output logic [9:0]  w5,
    output logic [9:0]  w6,
    output logic [9:0]  w7,
    output logic [9:0]  w8,
    output logic [9:0]  x,
    output logic        s0,
    output logic        s1,
    output logic        s2,
    output logic        z,
    output logic        sg,
    output logic        busy,
    output logic        done,
    output logic        wr_rej,
    output logic [15:0] upd_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  w_q [8];
    logic [9:0]  w_d [8];
    logic [9:0]  w_new [8];
    logic [9:0]  x_q, x_d;
    logic [2:0]  s_q, s_d;
    logic        z_q, z_d;
    logic        sg_q, sg_d;
    logic        skip_q, skip_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wr_rej_q, wr_rej_d;
    logic [15:0] upd_cnt_q, upd_cnt_d;
    logic        err_zero;

    assign err_zero = (err == 10'd0);
    assign w_new = '{W1, W2, W3, W4, W5, W6, W7, W8};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        x_d       = x_q;
        s_d       = s_q;
        z_d       = z_q;
        sg_d      = sg_q;
        skip_d    = skip_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_rej_d  = 1'b0;
        upd_cnt_d = upd_cnt_q;
        case (state_q)
            IDLE: begin
                // A host write in the accept cycle lands before SETTLE, so the block sees it
                if (wr_en) w_d[wr_addr] = wr_data;
                if (start) begin
                    x_d     = x_in;
                    s_d     = mu_sel;
                    sg_d    = err[9];
                    z_d     = err_zero;
                    skip_d  = freeze | err_zero;
                    cnt_d   = 4'(SETTLE_CYC - 1);
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (wr_en) wr_rej_d = 1'b1;
                if (cnt_q == 4'd0) state_d = COMMIT;
                else cnt_d = cnt_q - 4'd1;
            end
            COMMIT: begin
                if (wr_en) wr_rej_d = 1'b1;
                if (!skip_q) begin
                    w_d       = w_new;
                    upd_cnt_d = upd_cnt_q + 16'd1;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            w_q       <= '{default: '0};
            x_q       <= '0;
            s_q       <= '0;
            z_q       <= 1'b0;
            sg_q      <= 1'b0;
            skip_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_rej_q  <= 1'b0;
            upd_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_q       <= w_d;
            x_q       <= x_d;
            s_q       <= s_d;
            z_q       <= z_d;
            sg_q      <= sg_d;
            skip_q    <= skip_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_rej_q  <= wr_rej_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end

    assign w1 = w_q[0];
    assign w2 = w_q[1];
    assign w3 = w_q[2];
    assign w4 = w_q[3];
    assign w5 = w_q[4];
    assign w6 = w_q[5];
    assign w7 = w_q[6];
    assign w8 = w_q[7];
    assign x       = x_q;
    assign {s2, s1, s0} = s_q;
    assign z       = z_q;
    assign sg      = sg_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_rej  = wr_rej_q;
    assign upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_mab_ctrl.sv
// Scoreboard bench for mab_ctrl: each issued update pushes its expected commit result,
// and a monitor compares weights and update count whenever done pulses.
module tb_mab_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  x_in = '0;
    logic [9:0]  err = '0;
    logic [2:0]  mu_sel = '0;
    logic        freeze = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [9:0]  wr_data = '0;
    logic [9:0]  wb [8];
    logic [9:0]  wo [8];
    logic [9:0]  x;
    logic        s0, s1, s2, z, sg, busy, done, wr_rej;
    logic [15:0] upd_cnt;

    typedef struct packed {
        logic [7:0][9:0] w;
        logic [15:0]     cnt;
    } exp_t;

    exp_t            sb [$];
    logic [7:0][9:0] wm = '0;
    logic [15:0]     cntm = '0;
    int              n_chk = 0;
    int              n_fail = 0;
    int              n_done = 0;

    mab_ctrl #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .err(err),
        .mu_sel(mu_sel), .freeze(freeze), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data),
        .W1(wb[0]), .W2(wb[1]), .W3(wb[2]), .W4(wb[3]),
        .W5(wb[4]), .W6(wb[5]), .W7(wb[6]), .W8(wb[7]),
        .w1(wo[0]), .w2(wo[1]), .w3(wo[2]), .w4(wo[3]),
        .w5(wo[4]), .w6(wo[5]), .w7(wo[6]), .w8(wo[7]),
        .x(x), .s0(s0), .s1(s1), .s2(s2), .z(z), .sg(sg),
        .busy(busy), .done(done), .wr_rej(wr_rej), .upd_cnt(upd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending update");
            end else begin
                e = sb.pop_front();
                for (int i = 0; i < 8; i++)
                    chk($sformatf("commit_w%0d", i + 1), 32'(wo[i]), 32'(e.w[i]));
                chk("commit_upd_cnt", 32'(upd_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic check_model(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_w%0d", tag, i + 1), 32'(wo[i]), 32'(wm[i]));
        chk({tag, "_upd_cnt"}, 32'(upd_cnt), 32'(cntm));
    endtask

    task automatic set_w(input logic [9:0] base);
        for (int i = 0; i < 8; i++) wb[i] = base + 10'(i);
    endtask

    task automatic push_exp(input logic skip, input logic [9:0] base);
        exp_t e;
        if (!skip) begin
            for (int i = 0; i < 8; i++) wm[i] = base + 10'(i);
            cntm = cntm + 16'd1;
        end
        e.w   = wm;
        e.cnt = cntm;
        sb.push_back(e);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [9:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        wm[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Accept one update (optionally with a simultaneous host write); returns mid-cycle after accept.
    task automatic run_update(input logic [9:0] xv, input logic [9:0] ev, input logic [2:0] mu,
                              input logic frz, input logic [9:0] base,
                              input logic we, input logic [2:0] wa, input logic [9:0] wd);
        @(negedge clk);
        start = 1'b1; x_in = xv; err = ev; mu_sel = mu; freeze = frz;
        wr_en = we; wr_addr = wa; wr_data = wd;
        set_w(base);
        if (we) wm[wa] = wd;
        push_exp(frz | (ev == 10'd0), base);
        @(posedge clk); #1;
        chk("cap_x", 32'(x), 32'(xv));
        chk("cap_sel", 32'({s2, s1, s0}), 32'(mu));
        chk("cap_sg", 32'(sg), 32'(ev[9]));
        chk("cap_z", 32'(z), 32'(ev == 10'd0));
        chk("cap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        x_in = ~xv; err = ~ev; mu_sel = ~mu; freeze = ~frz;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: got busy=1 after 20 cycles, expected 0", tag);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int d0;
        set_w(10'h000);

        // Reset values
        #12;
        for (int i = 0; i < 8; i++) chk($sformatf("rst_w%0d", i + 1), 32'(wo[i]), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_ctl", 32'({s2, s1, s0, z, sg, busy, done, wr_rej}), 32'd0);
        chk("rst_upd_cnt", 32'(upd_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Host writes in IDLE
        host_write(3'd2, 10'h00A);
        host_write(3'd7, 10'h3F0);
        check_model("wr");

        // Normal update with done timing
        run_update(10'h055, 10'h3FE, 3'd5, 1'b0, 10'h011, 1'b0, 3'd0, 10'h000);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            chk($sformatf("done_after_k%0d", j), 32'(done), 32'(j == 3));
            chk($sformatf("busy_after_k%0d", j), 32'(busy), 32'(j < 3));
        end
        chk("hold_x", 32'(x), 32'h055);
        chk("hold_sel", 32'({s2, s1, s0}), 32'd5);
        chk("hold_sg_z", 32'({sg, z}), 32'b10);

        // Zero error, then frozen update: no commit
        run_update(10'h1AB, 10'h000, 3'd3, 1'b0, 10'h100, 1'b0, 3'd0, 10'h000);
        wait_idle("zero_err");
        run_update(10'h0CC, 10'h004, 3'd2, 1'b1, 10'h200, 1'b0, 3'd0, 10'h000);
        wait_idle("freeze");
        check_model("skip");

        // Host write during SETTLE is rejected
        run_update(10'h001, 10'h3FF, 3'd1, 1'b1, 10'h300, 1'b0, 3'd0, 10'h000);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 10'h1FF;
        @(posedge clk); #1;
        chk("wr_rej_pulse", 32'(wr_rej), 32'd1);
        wr_en = 1'b0;
        @(posedge clk); #1;
        chk("wr_rej_clear", 32'(wr_rej), 32'd0);
        wait_idle("wr_rej");

        // Host write together with start
        run_update(10'h077, 10'h010, 3'd4, 1'b0, 10'h080, 1'b1, 3'd2, 10'h123);
        chk("wr_with_start_w3", 32'(wo[2]), 32'h123);
        wait_idle("wr_start");

        // Start held high: accepts at edges 0, 4, 8
        @(negedge clk);
        start = 1'b1; x_in = 10'h2AA; err = 10'h010; mu_sel = 3'd7; freeze = 1'b0;
        set_w(10'h040);
        for (int i = 0; i < 3; i++) push_exp(1'b0, 10'h040);
        d0 = n_done;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_busy_%0d", j), 32'(busy), 32'((j % 4) != 3));
            if (j == 8) start = 1'b0;
        end
        @(negedge clk); #1;
        chk("b2b_done_count", 32'(n_done - d0), 32'd3);

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1; x_in = 10'h0F0; err = 10'h020; freeze = 1'b0;
        set_w(10'h1C0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        wm = '0; cntm = '0;
        check_model("midrst");
        @(negedge clk); rst_n = 1'b1;
        d0 = n_done;
        repeat (6) @(negedge clk);
        #1;
        chk("midrst_no_done", 32'(n_done - d0), 32'd0);

        // Update counter wrap
        @(negedge clk);
        force dut.upd_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.upd_cnt_q;
        cntm = 16'hFFFE;
        #1;
        chk("preload_upd_cnt", 32'(upd_cnt), 32'hFFFE);
        run_update(10'h111, 10'h2F0, 3'd6, 1'b0, 10'h020, 1'b0, 3'd0, 10'h000);
        wait_idle("wrap1");
        run_update(10'h222, 10'h00F, 3'd0, 1'b0, 10'h030, 1'b0, 3'd0, 10'h000);
        wait_idle("wrap2");
        chk("wrap_upd_cnt", 32'(upd_cnt), 32'h0000);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mab_ctrl.md
# mab_ctrl

Sequencer and weight store for the 8-tap modified adder block of the LMS adaptive filter. Holds the eight 10-bit tap weights and presents them to the adder block. On each update request it captures the input sample, the error, and the step-size select, and drives the shared select, zero and sign controls. After a fixed settle window it commits the adder block's updated weights back into its registers. It also provides a host write port for weight initialisation and a running update counter.

## Interface
- SETTLE_CYC, 2: cycles the combinational adder block is given to settle before commit; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  update request; accepted only in IDLE.
- x_in  in  10  input sample for this update.
- err  in  10  two's-complement error for this update.
- mu_sel  in  3  step-size select.
- freeze  in  1  sampled with start; when 1 the update runs but commits nothing.
- wr_en  in  1  host weight write strobe.
- wr_addr  in  3  weight index 0..7 (maps to w1..w8).
- wr_data  in  10  host write data.
- W1..W8  in  10 each  updated weights from the adder block.
- w1..w8  out  10 each  registered tap weights to the adder block.
- x  out  10  registered sample to the adder block.
- s0, s1, s2  out  1 each  registered step select to the adder block.
- z  out  1  registered zero-error flag.
- sg  out  1  registered error sign.
- busy  out  1  high from the accept edge until the return to IDLE.
- done  out  1  one-cycle pulse after the commit edge.
- wr_rej  out  1  one-cycle pulse when a write is dropped because the block is busy.
- upd_cnt  out  16  count of committed updates; wraps modulo 2^16.

## Operation
- States: IDLE, SETTLE, COMMIT.
- IDLE, start=1, accept edge:
  - x <= x_in.
  - {s2,s1,s0} <= mu_sel.
  - sg <= err[9].
  - z <= (err == 0).
  - Internal skip flag <= freeze | (err == 0).
  - cnt <= SETTLE_CYC-1.
  - busy <= 1; go to SETTLE.
- SETTLE: if cnt == 0 go to COMMIT, else cnt decrements.
- COMMIT, one edge:
  - If skip is 0: w1..w8 <= W1..W8, and upd_cnt increments.
  - If skip is 1: weights and upd_cnt are unchanged.
  - In both cases: done <= 1, busy <= 0, go to IDLE.
- x, s0..s2, z and sg hold their captured values after the update, until the next accept.
- Host writes:
  - In IDLE, wr_en=1 writes wr_data into weight wr_addr at that edge.
  - In SETTLE or COMMIT, a write is dropped and wr_rej pulses for one cycle.
- Simultaneous events:
  - wr_en and start in the same IDLE cycle: both are accepted. The written weight is visible to the adder block during SETTLE.
  - start while busy: ignored, not queued.
- All captured values are held for the whole operation; input changes during SETTLE have no effect.

## Timing
- Reset values (asynchronous): all w1..w8 = 0, x = 0, s0..s2 = 0, z = 0, sg = 0, busy = 0, done = 0, wr_rej = 0, upd_cnt = 0, state IDLE.
- Latency with start accepted at edge k:
  - busy is high after edge k.
  - COMMIT is entered at edge k+SETTLE_CYC.
  - Weights update and done rises at edge k+SETTLE_CYC+1.
  - busy is low and done is low again after edge k+SETTLE_CYC+2.
- Earliest next accept is edge k+SETTLE_CYC+2, i.e. start held high back-to-back gives one update every SETTLE_CYC+2 cycles.
- Reset asserted mid-operation: immediate return to IDLE with reset values. No done pulse; weights are cleared.
- upd_cnt at 0xFFFF with a committing update goes to 0x0000.

## Test plan
- Reset, then host-write 0x00A to w3 and 0x3F0 to w8 in IDLE -> w3=0x00A and w8=0x3F0 the next cycle; all other weights 0; upd_cnt=0.
- SETTLE_CYC=2; start at edge k with x_in=0x055, err=0x3FE, mu_sel=5, and W1..W8 driven as 0x011..0x018 -> x=0x055, {s2,s1,s0}=101, sg=1, z=0 after edge k; done high only between edges k+3 and k+4; w1..w8 = 0x011..0x018; upd_cnt=1.
- start with err=0 -> z=1; done pulses; weights and upd_cnt unchanged. Repeat with err=0x004 and freeze=1 -> same result, with sg=0.
- wr_en to w1 during SETTLE -> wr_rej pulses once; w1 unchanged. wr_en together with start in IDLE -> write lands and the update proceeds normally.
- Hold start high for 3 updates -> accepts at edges 0, 4, 8; exactly 3 done pulses; upd_cnt=3.
- Assert rst_n low at edge k+1 of an update -> busy=0 immediately, no done, all weights 0. Separately, 65,536 committed updates -> upd_cnt wraps to 0.
